shiftare_iterativa: RTL and testbench
=====================================

// Module: shiftare_iterativa
// PURPOSE
//  Multi-cycle ALU shift unit: shifts operand A left or right by a variable amount,
//  one bit position per clock, under a start/done handshake.
//  Sits beside the single-bit combinational shifters in the ALU datapath and
//  replaces chains of them for shifts by 0..WIDTH-1 positions.
// PARAMETERS
//  WIDTH  32                operand/result width in bits (>=2)
//  CNT_W  $clog2(WIDTH)     width of the shift-amount port; derived, do not override
// PORTS
//  clk       in   1      clock, all state updates on rising edge
//  rst_n     in   1      asynchronous reset, active low
//  start     in   1      request; sampled only in IDLE
//  op        in   2      00=SLL, 01=SRL, 10=SRA, 11=ROR (ROR only with SHIFT_ROTATE_EN)
//  A         in   WIDTH  operand, captured on accepted start
//  amount    in   CNT_W  shift count, captured on accepted start
//  busy      out  1      high while shifting (state SHIFT)
//  done      out  1      one-cycle pulse: rezultat/carry are valid
//  rezultat  out  WIDTH  shifted operand; held until the next accepted start
//  carry     out  1      last bit shifted (or rotated) out; 0 if amount==0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, rezultat=0, carry=0, counter=0.
//  Reset mid-operation aborts immediately; no done pulse is produced.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE:  start=1 -> capture A into rezultat, amount into counter, op into op_q, carry<=0;
//          next = SHIFT if amount!=0, else DONE.
//   SHIFT: per clock one shift of rezultat per op_q, counter<=counter-1;
//          next = DONE when counter==1 (last shift done this edge).
//   DONE:  done=1 for exactly this cycle; next = IDLE unconditionally.
//  Latency: start high in cycle 0 -> busy high cycles 1..amount -> done high in cycle amount+1.
//  start while in SHIFT or DONE is ignored (not queued); A/amount/op changes after capture have no effect.
//  Per-step shift (r = rezultat, W = WIDTH):
//   SLL: carry<=r[W-1]; r<={r[W-2:0],1'b0}
//   SRL: carry<=r[0];   r<={1'b0,r[W-1:1]}
//   SRA: carry<=r[0];   r<={r[W-1],r[W-1:1]}  (sign replicated)
//   ROR: carry<=r[0];   r<={r[0],r[W-1:1]}
//  rezultat and carry change only in SHIFT or on start capture; stable in DONE and IDLE.
//  amount is unsigned; full range 0..WIDTH-1 legal, no wrap of counter below 0.
// CONFIGURATION
//  SHIFT_ROTATE_EN defined: op=11 performs rotate-right as above.
//  SHIFT_ROTATE_EN undefined: op=11 is treated as amount 0 regardless of the amount
//   port: capture A, go straight to DONE, rezultat=A, carry=0; no rotate logic synthesised.
// TESTING
//  Reset: assert rst_n=0 mid-SHIFT -> busy=0, done=0, rezultat=0 at once; no later done pulse.
//  SLL A=32'h8000_0001, amount=1 -> done in cycle 2, rezultat=32'h0000_0002, carry=1.
//  SRA A=32'h8000_00F0, amount=4 -> busy cycles 1..4, done cycle 5, rezultat=32'hF800_000F, carry=0.
//  SRL A=32'hFFFF_FFFF, amount=31 -> rezultat=32'h0000_0001, carry=1; start pulsed mid-shift ignored.
//  amount=0, any op, A=32'h1234_5678 -> done in cycle 1, busy never high, rezultat=A, carry=0.
//  op=11 A=32'h0000_0003 amount=1: with SHIFT_ROTATE_EN -> 32'h8000_0001, carry=1;
//   without -> done in cycle 1, rezultat=32'h0000_0003, carry=0.

Source files
------------

// File: rtl/shiftare_iterativa.sv
// Iterative shift unit that shifts one bit per clock under a start/done handshake.
// Define SHIFT_ROTATE_EN to make op=11 perform a rotate-right; otherwise op=11 passes A through.
module shiftare_iterativa #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [CNT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rezultat,
  output logic             carry
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SHIFT = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic [1:0]       state_q, state_n;
  logic [CNT_W-1:0] counter_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] rez_q;
  logic             carry_q;
  logic             busy_q, done_q;
  logic [CNT_W-1:0] amount_eff_c;
  logic [WIDTH-1:0] shift_r_c;
  logic             shift_c_c;

  // Effective shift count captured on start
  always_comb begin
    amount_eff_c = amount;
`ifndef SHIFT_ROTATE_EN
    if (op == OP_ROR) amount_eff_c = '0;
`endif
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_n = (amount_eff_c == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (counter_q == CNT_W'(1)) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // One-position shift of the working register
  always_comb begin
    shift_r_c = rez_q;
    shift_c_c = carry_q;
    case (op_q)
      OP_SLL: begin
        shift_c_c = rez_q[WIDTH-1];
        shift_r_c = {rez_q[WIDTH-2:0], 1'b0};
      end
      OP_SRL: begin
        shift_c_c = rez_q[0];
        shift_r_c = {1'b0, rez_q[WIDTH-1:1]};
      end
      OP_SRA: begin
        shift_c_c = rez_q[0];
        shift_r_c = {rez_q[WIDTH-1], rez_q[WIDTH-1:1]};
      end
`ifdef SHIFT_ROTATE_EN
      OP_ROR: begin
        shift_c_c = rez_q[0];
        shift_r_c = {rez_q[0], rez_q[WIDTH-1:1]};
      end
`endif
      default: begin
        shift_r_c = rez_q;
        shift_c_c = carry_q;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_n;
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= '0;
      op_q      <= OP_SLL;
      rez_q     <= '0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q <= (state_n == S_SHIFT);
      done_q <= (state_n == S_DONE);
      if (state_q == S_IDLE && start) begin
        counter_q <= amount_eff_c;
        op_q      <= op;
        rez_q     <= A;
        carry_q   <= 1'b0;
      end else if (state_q == S_SHIFT) begin
        counter_q <= counter_q - CNT_W'(1);
        rez_q     <= shift_r_c;
        carry_q   <= shift_c_c;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rezultat = rez_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_shiftare_iterativa.sv
// Directed self-checking bench for shiftare_iterativa (default WIDTH=32).
module tb_shiftare_iterativa;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 5;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [CNT_W-1:0] amount;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rezultat;
  logic             carry;

  int n_checks = 0;
  int n_errors = 0;

  shiftare_iterativa #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .A        (A),
    .amount   (amount),
    .busy     (busy),
    .done     (done),
    .rezultat (rezultat),
    .carry    (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start an operation, follow it cycle by cycle, optionally pulse start mid-run.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] a,
                        input int amt, input int amt_eff, input logic [WIDTH-1:0] exp_r,
                        input logic exp_c, input int inject);
    int done_cyc;
    done_cyc = 0;
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    A      = a;
    amount = CNT_W'(amt);
    for (int c = 1; c <= amt_eff + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        A     = ~a;
        op    = ~o;
        amount = CNT_W'(amt + 3);
      end
      chk({tag, " busy"}, WIDTH'(busy), WIDTH'((c >= 1 && c <= amt_eff) ? 1 : 0));
      if (done && done_cyc == 0) done_cyc = c;
      if (c == amt_eff + 1 || c == amt_eff + 2) begin
        chk({tag, " rezultat"}, rezultat, exp_r);
        chk({tag, " carry"}, WIDTH'(carry), WIDTH'(exp_c));
      end
      if (c == amt_eff + 2) chk({tag, " done_after"}, WIDTH'(done), '0);
      if (inject > 0 && c == inject) start = 1'b1;
      if (inject > 0 && c == inject + 1) start = 1'b0;
    end
    chk({tag, " done_cycle"}, WIDTH'(done_cyc), WIDTH'(amt_eff + 1));
  endtask

  initial begin
    int seen_done;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    A      = '0;
    amount = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", WIDTH'(busy), '0);
    chk("rst done", WIDTH'(done), '0);
    chk("rst rezultat", rezultat, '0);
    chk("rst carry", WIDTH'(carry), '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("sll1",   2'b00, 32'h8000_0001, 1,  1,  32'h0000_0002, 1'b1, 0);
    run_op("sra4",   2'b10, 32'h8000_00F0, 4,  4,  32'hF800_000F, 1'b0, 0);
    run_op("srl31",  2'b01, 32'hFFFF_FFFF, 31, 31, 32'h0000_0001, 1'b1, 10);
    run_op("sll0",   2'b00, 32'h1234_5678, 0,  0,  32'h1234_5678, 1'b0, 0);
    run_op("sra0",   2'b10, 32'h1234_5678, 0,  0,  32'h1234_5678, 1'b0, 0);
    run_op("sll31",  2'b00, 32'h0000_0001, 31, 31, 32'h8000_0000, 1'b0, 0);
    run_op("srl4",   2'b01, 32'h0000_000F, 4,  4,  32'h0000_0000, 1'b1, 2);
    run_op("sra3p",  2'b10, 32'h4000_0000, 3,  3,  32'h0800_0000, 1'b0, 0);
    run_op("sra5n",  2'b10, 32'hFFFF_FFF0, 5,  5,  32'hFFFF_FFFF, 1'b1, 0);
`ifdef SHIFT_ROTATE_EN
    run_op("ror1",   2'b11, 32'h0000_0003, 1,  1,  32'h8000_0001, 1'b1, 0);
`else
    run_op("ror1",   2'b11, 32'h0000_0003, 1,  0,  32'h0000_0003, 1'b0, 0);
`endif

    // Reset in the middle of a shift aborts at once
    @(negedge clk);
    start  = 1'b1;
    op     = 2'b00;
    A      = 32'h0000_0001;
    amount = CNT_W'(10);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid busy_before", WIDTH'(busy), WIDTH'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst busy", WIDTH'(busy), '0);
    chk("mid_rst done", WIDTH'(done), '0);
    chk("mid_rst rezultat", rezultat, '0);
    chk("mid_rst carry", WIDTH'(carry), '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    chk("mid_rst no_done", WIDTH'(seen_done), '0);

    run_op("post_rst", 2'b01, 32'h0000_0100, 8, 8, 32'h0000_0001, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
